// File: rtl/rice_core_if_stage.sv
// Instruction fetch stage: credit-limited word requests, in-order response buffer, registered result to decode.
// Optional RICE_CORE_IF_FETCH_ERROR_EN carries a per-instruction fetch error bit alongside each result.

module rice_core_if_stage #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FIFO_DEPTH   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    input  logic            i_stall,
    output logic            o_inst_req_valid,
    input  logic            i_inst_req_ready,
    output logic [XLEN-1:0] o_inst_req_addr,
    input  logic            i_inst_resp_valid,
    input  logic [31:0]     i_inst_resp_data,
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
    input  logic            i_inst_resp_error,
    output logic            o_if_fetch_error,
`endif
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_inst
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  resp_pc;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [XLEN-1:0]  fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_inst [FIFO_DEPTH];
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
    logic             fifo_err  [FIFO_DEPTH];
`endif

    logic [CNT_W:0]   in_use;
    logic             req_valid;
    logic             fire;
    logic             keep;
    logic             load;
    logic             fifo_empty;
    logic             pop;
    logic             bypass;
    logic             push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Request credit, response disposition and result-load decisions.
    always_comb begin
        in_use     = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(outstanding);
        req_valid  = !i_rst && i_enable && !i_flush && (in_use < (CNT_W + 1)'(FIFO_DEPTH));
        fire       = req_valid && i_inst_req_ready;
        keep       = i_inst_resp_valid && !i_flush && (discard == '0);
        load       = (!o_if_valid || !i_stall) && i_enable && !i_flush;
        fifo_empty = (fifo_count == '0);
        pop        = load && !fifo_empty;
        bypass     = load && fifo_empty && keep;
        push       = keep && !bypass;
    end

    assign o_inst_req_valid = req_valid;
    assign o_inst_req_addr  = pc;

    // Buffer storage carries no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= i_inst_resp_data;
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
            fifo_err[wr_ptr]  <= i_inst_resp_error;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc          <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            o_if_valid  <= 1'b0;
            o_if_pc     <= '0;
            o_if_inst   <= '0;
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
            o_if_fetch_error <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(i_inst_resp_valid);
            if (i_flush) begin
                // Everything still in flight after this cycle belongs to the old stream.
                pc         <= i_flush_pc & ~XLEN'(3);
                resp_pc    <= i_flush_pc & ~XLEN'(3);
                discard    <= outstanding - CNT_W'(i_inst_resp_valid);
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                o_if_valid <= 1'b0;
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
                o_if_fetch_error <= 1'b0;
`endif
            end else begin
                if (fire) begin
                    pc <= pc + XLEN'(4);
                end
                if (i_inst_resp_valid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (keep) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

                if (load) begin
                    o_if_valid <= pop || bypass;
                    if (pop) begin
                        o_if_pc   <= fifo_pc[rd_ptr];
                        o_if_inst <= fifo_inst[rd_ptr];
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
                        o_if_fetch_error <= fifo_err[rd_ptr];
`endif
                    end else if (bypass) begin
                        o_if_pc   <= resp_pc;
                        o_if_inst <= i_inst_resp_data;
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
                        o_if_fetch_error <= i_inst_resp_error;
`endif
                    end
                end else if (!i_enable) begin
                    o_if_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rice_core_if_stage.sv
// Randomized bench for rice_core_if_stage against a queue-based fetch model, plus directed literal scenarios.
// Checks o_if_fetch_error when RICE_CORE_IF_FETCH_ERROR_EN is defined.

module tb_rice_core_if_stage;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        stall = 1'b0;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        resp_error = 1'b0;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_err;

    rice_core_if_stage #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (enable),
        .i_flush          (flush),
        .i_flush_pc       (flush_pc),
        .i_stall          (stall),
        .o_inst_req_valid (req_valid),
        .i_inst_req_ready (req_ready),
        .o_inst_req_addr  (req_addr),
        .i_inst_resp_valid(resp_valid),
        .i_inst_resp_data (resp_data),
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
        .i_inst_resp_error(resp_error),
        .o_if_fetch_error (if_err),
`endif
        .o_if_valid       (if_valid),
        .o_if_pc          (if_pc),
        .o_if_inst        (if_inst)
    );

`ifndef RICE_CORE_IF_FETCH_ERROR_EN
    assign if_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    // Behavioural model: issue pointer, in-flight queue, instruction buffer, displayed result.
    logic [31:0] m_pc;
    logic [31:0] m_out_pc [$];
    bit          m_out_drop [$];
    logic [31:0] m_buf_pc [$];
    logic [31:0] m_buf_inst [$];
    bit          m_buf_err [$];
    bit          m_v;
    logic [31:0] m_opc;
    logic [31:0] m_oinst;
    bit          m_oerr;

    logic [31:0] bus_addr [$];
    int          bus_cyc [$];

    bit          lg_req  [64];
    logic [31:0] lg_addr [64];
    bit          lg_v    [64];
    logic [31:0] lg_pc   [64];
    logic [31:0] lg_inst [64];
    bit          lg_err  [64];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; flush = 1'b0; stall = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_if_valid", 32'(if_valid), 32'd0);
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_inst", if_inst, 32'h0);
        chk("reset_req_valid", 32'(req_valid), 32'd0);
        m_pc = 32'h0; m_v = 1'b0; m_oerr = 1'b0; m_opc = '0; m_oinst = '0;
        m_out_pc.delete(); m_out_drop.delete();
        m_buf_pc.delete(); m_buf_inst.delete(); m_buf_err.delete();
        bus_addr.delete(); bus_cyc.delete();
        cyc = 0;
    endtask

    // One clock cycle: drive, check DUT against model, advance model.
    task automatic step(input bit en, input bit fl, input logic [31:0] fpc, input bit st,
                        input bit rdy, input bit rok, input bit emode);
        bit          r;
        bit          exp_req;
        bit          fire;
        bit          kept;
        bit          d;
        logic [31:0] a;
        logic [31:0] p;
        @(negedge clk);
        rst = 1'b0; enable = en; flush = fl; flush_pc = fpc; stall = st; req_ready = rdy;
        r = rok && (bus_addr.size() > 0) && ((cyc - bus_cyc[0]) >= 1);
        if (r) begin
            a = bus_addr.pop_front();
            void'(bus_cyc.pop_front());
            resp_valid = 1'b1;
            resp_data  = mem(a);
            resp_error = emode ? (a == 32'h8) : ($urandom_range(0, 7) == 0);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
            resp_error = 1'($urandom_range(0, 1));
        end
        #1;
        exp_req = en && !fl && ((m_buf_pc.size() + m_out_pc.size()) < DEPTH);
        chk("req_valid", 32'(req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", req_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_v));
        if (m_v) begin
            chk("if_pc", if_pc, m_opc);
            chk("if_inst", if_inst, m_oinst);
`ifdef RICE_CORE_IF_FETCH_ERROR_EN
            chk("if_fetch_error", 32'(if_err), 32'(m_oerr));
`endif
        end
        if (cyc < 64) begin
            lg_req[cyc] = req_valid; lg_addr[cyc] = req_addr; lg_v[cyc] = if_valid;
            lg_pc[cyc] = if_pc; lg_inst[cyc] = if_inst; lg_err[cyc] = if_err;
        end
        fire = exp_req && rdy;
        if (fire) begin
            bus_addr.push_back(req_addr);
            bus_cyc.push_back(cyc);
        end

        kept = 1'b0;
        p = '0;
        if (r && (m_out_pc.size() > 0)) begin
            p = m_out_pc.pop_front();
            d = m_out_drop.pop_front();
            kept = !fl && !d;
        end
        if (fl) begin
            foreach (m_out_drop[i]) m_out_drop[i] = 1'b1;
            m_buf_pc.delete(); m_buf_inst.delete(); m_buf_err.delete();
            m_v = 1'b0;
            m_oerr = 1'b0;
            m_pc = fpc & 32'hFFFF_FFFC;
        end else begin
            if (fire) begin
                m_out_pc.push_back(m_pc);
                m_out_drop.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
            if (kept) begin
                m_buf_pc.push_back(p);
                m_buf_inst.push_back(resp_data);
                m_buf_err.push_back(resp_error);
            end
            if ((!m_v || !st) && en) begin
                if (m_buf_pc.size() > 0) begin
                    m_opc = m_buf_pc.pop_front();
                    m_oinst = m_buf_inst.pop_front();
                    m_oerr = m_buf_err.pop_front();
                    m_v = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
            end else if (!en) begin
                m_v = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        int n;
        logic [31:0] fpc;

        // Streaming after reset: bus always ready, 1-cycle latency.
        do_reset();
        repeat (6) step(1, 0, 0, 0, 1, 1, 0);
        chk("A_req0", 32'(lg_req[0]), 32'd1);
        chk("A_addr0", lg_addr[0], 32'h0);
        chk("A_addr1", lg_addr[1], 32'h4);
        chk("A_addr2", lg_addr[2], 32'h8);
        chk("A_v1", 32'(lg_v[1]), 32'd0);
        chk("A_v2", 32'(lg_v[2]), 32'd1);
        chk("A_pc2", lg_pc[2], 32'h0);
        chk("A_inst2", lg_inst[2], mem(32'h0));
        chk("A_pc3", lg_pc[3], 32'h4);
        chk("A_pc4", lg_pc[4], 32'h8);

        // Stall with pc 0 displayed: buffer fills to the credit limit, then drains in order.
        do_reset();
        repeat (2) step(1, 0, 0, 0, 1, 1, 0);
        repeat (5) step(1, 0, 0, 1, 1, 1, 0);
        repeat (4) step(1, 0, 0, 0, 1, 1, 0);
        for (int i = 2; i <= 6; i++) chk("B_hold_pc", lg_pc[i], 32'h0);
        n = 0;
        for (int i = 1; i <= 6; i++) n += int'(lg_req[i]);
        chk("B_fires", 32'(n), 32'd2);
        chk("B_req3", 32'(lg_req[3]), 32'd0);
        chk("B_req6", 32'(lg_req[6]), 32'd0);
        chk("B_pc8", lg_pc[8], 32'h4);
        chk("B_pc9", lg_pc[9], 32'h8);
        chk("B_addr8", lg_addr[8], 32'hC);

        // Flush with two requests in flight: old responses dropped, fetch restarts aligned.
        do_reset();
        step(1, 1, 32'h10, 0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 32'h103, 0, 1, 0, 0);
        repeat (6) step(1, 0, 0, 0, 1, 1, 0);
        chk("C_addr1", lg_addr[1], 32'h10);
        chk("C_addr2", lg_addr[2], 32'h14);
        chk("C_req3", 32'(lg_req[3]), 32'd0);
        chk("C_addr4", lg_addr[4], 32'h100);
        for (int i = 4; i <= 6; i++) chk("C_dropped", 32'(lg_v[i]), 32'd0);
        chk("C_v7", 32'(lg_v[7]), 32'd1);
        chk("C_pc7", lg_pc[7], 32'h100);
        chk("C_inst7", lg_inst[7], mem(32'h100));
        chk("C_pc8", lg_pc[8], 32'h104);

        // Bus not ready for 3 cycles: address holds.
        do_reset();
        step(1, 1, 32'h20, 0, 1, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("D_addr_hold", lg_addr[i], 32'h20);
            chk("D_req_hold", 32'(lg_req[i]), 32'd1);
        end
        chk("D_addr5", lg_addr[5], 32'h24);

        // Disable with one request in flight.
        do_reset();
        step(1, 0, 0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 1, 0);
        repeat (4) step(1, 0, 0, 0, 1, 1, 0);
        for (int i = 1; i <= 3; i++) chk("E_no_req", 32'(lg_req[i]), 32'd0);
        for (int i = 1; i <= 4; i++) chk("E_no_valid", 32'(lg_v[i]), 32'd0);
        chk("E_addr4", lg_addr[4], 32'h4);
        chk("E_v5", 32'(lg_v[5]), 32'd1);
        chk("E_pc5", lg_pc[5], 32'h0);
        chk("E_pc6", lg_pc[6], 32'h4);

`ifdef RICE_CORE_IF_FETCH_ERROR_EN
        // Fetch error on pc 0x8 only.
        do_reset();
        repeat (7) step(1, 0, 0, 0, 1, 1, 1);
        chk("F_pc4", lg_pc[4], 32'h8);
        chk("F_err2", 32'(lg_err[2]), 32'd0);
        chk("F_err3", 32'(lg_err[3]), 32'd0);
        chk("F_err4", 32'(lg_err[4]), 32'd1);
        chk("F_err5", 32'(lg_err[5]), 32'd0);
`endif

        // Randomized traffic including redirects near the address-space wrap.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 24) == 0),
                 fpc,
                 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 6),
                 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
